// File: rtl/buffer_dispositivo_uscita.sv
// Output-side byte FIFO: captures interface writes on the strobe edge and
// hands bytes one by one to a slow device over a dav_/rfd handshake.
module buffer_dispositivo_uscita #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    byte_in,
  input  logic          strobe,
  input  logic          rfd,
  input  logic          ovr_clr,
  output logic [7:0]    byte_dev,
  output logic          dav_,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_OFFER   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Synchronizers run free so a strobe already high during reset yields no edge.
  logic stb_s1_q, stb_s2_q, stb_s3_q;
  logic rfd_s1_q, rfd_s2_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    byte_dev_q, byte_dev_d;
  logic          dav_q, dav_d;
  logic          overrun_q, overrun_d;

  logic push_req, push, pop, rfd_s, full_w;

  assign rfd_s  = rfd_s2_q;
  assign full_w = (count_q == CNT_FULL);

  always_comb begin
    push_req   = stb_s2_q & ~stb_s3_q & ~reset;
    pop        = (state_q == S_OFFER) & ~rfd_s;
    // A pop on the same edge frees the slot, so the push is still accepted.
    push       = push_req & (~full_w | pop);

    state_d    = state_q;
    byte_dev_d = byte_dev_q;
    dav_d      = dav_q;
    case (state_q)
      S_IDLE: begin
        dav_d = 1'b1;
        if ((count_q != '0) && rfd_s) begin
          byte_dev_d = mem_q[rd_ptr_q];
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        dav_d   = 1'b0;
        state_d = S_OFFER;
      end
      S_OFFER: begin
        if (!rfd_s) begin
          dav_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (rfd_s) state_d = S_IDLE;
      end
      default: begin
        dav_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push) count_d = count_d + CNT_ONE;
    if (pop)  count_d = count_d - CNT_ONE;

    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (push_req && full_w && !pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    stb_s1_q <= strobe;
    stb_s2_q <= stb_s1_q;
    stb_s3_q <= stb_s2_q;
    rfd_s1_q <= rfd;
    rfd_s2_q <= rfd_s1_q;
    if (push) mem_q[wr_ptr_q] <= byte_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      byte_dev_q <= 8'h00;
      dav_q      <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      byte_dev_q <= byte_dev_d;
      dav_q      <= dav_d;
      overrun_q  <= overrun_d;
    end
  end

  assign byte_dev = byte_dev_q;
  assign dav_     = dav_q;
  assign count    = count_q;
  assign full     = full_w;
  assign overrun  = overrun_q;

endmodule
